// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: request, response and DataMemory bus of the two-port arbiter
interface dmem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic [1:0]        req_valid;
    logic [1:0]        req_we;
    logic [ADDR_W-1:0] req_adr0;
    logic [ADDR_W-1:0] req_adr1;
    logic [DATA_W-1:0] req_wdata0;
    logic [DATA_W-1:0] req_wdata1;
    logic [1:0]        req_ready;
    logic [1:0]        rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_w;
    logic              mem_r;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  req_valid, req_we, req_adr0, req_adr1, req_wdata0, req_wdata1, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_adr, mem_wdata, mem_w, mem_r, busy
    );

    modport master (
        output req_valid, req_we, req_adr0, req_adr1, req_wdata0, req_wdata1, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_adr, mem_wdata, mem_w, mem_r, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of the single-ported DataMemory
module dmem_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter bit FIXED_PRIO = 1'b0
) (
    input logic            clk,
    input logic            reset,
    dmem_arbiter_if.slave  bus_io
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic              id_q, id_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] mem_adr_q, mem_adr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_w_q, mem_w_d;
    logic              mem_r_q, mem_r_d;
    logic [1:0]        rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              grant, accept, sel_we, misaligned;
    logic [ADDR_W-1:0] sel_adr;
    logic [DATA_W-1:0] sel_wdata;

    assign grant      = (bus_io.req_valid == 2'b10) |
                        ((bus_io.req_valid == 2'b11) & !FIXED_PRIO & !last_grant_q);
    assign accept     = (state_q == IDLE) & (|bus_io.req_valid);
    assign sel_adr    = grant ? bus_io.req_adr1 : bus_io.req_adr0;
    assign sel_wdata  = grant ? bus_io.req_wdata1 : bus_io.req_wdata0;
    assign sel_we     = bus_io.req_we[grant];
    assign misaligned = sel_adr[2:0] != 3'd0;

    assign bus_io.req_ready = accept ? {grant, !grant} : 2'b00;
    assign bus_io.busy      = state_q != IDLE;
    assign bus_io.mem_adr   = mem_adr_q;
    assign bus_io.mem_wdata = mem_wdata_q;
    assign bus_io.mem_w     = mem_w_q;
    assign bus_io.mem_r     = mem_r_q;
    assign bus_io.rsp_valid = rsp_valid_q;
    assign bus_io.rsp_err   = rsp_err_q;
    assign bus_io.rsp_rdata = rsp_rdata_q;

    // Next state and next values of the registered outputs, computed for the state being entered
    always_comb begin
        state_d      = state_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        mem_adr_d    = mem_adr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_w_d      = 1'b0;
        mem_r_d      = 1'b0;
        rsp_valid_d  = 2'b00;
        rsp_err_d    = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        unique case (state_q)
            IDLE: if (accept) begin
                id_d         = grant;
                last_grant_d = grant;
                if (misaligned) begin
                    state_d     = RESP;
                    rsp_valid_d = {grant, !grant};
                    rsp_err_d   = 1'b1;
                end else begin
                    state_d     = ISSUE;
                    mem_adr_d   = sel_adr;
                    mem_wdata_d = sel_wdata;
                    mem_w_d     = sel_we;
                    mem_r_d     = !sel_we;
                end
            end
            ISSUE: begin
                state_d     = mem_w_q ? RESP : WAIT;
                rsp_valid_d = mem_w_q ? {id_q, !id_q} : 2'b00;
            end
            WAIT: begin
                state_d     = RESP;
                rsp_rdata_d = bus_io.mem_rdata;
                rsp_valid_d = {id_q, !id_q};
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any in-flight request and favours port 0 next
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            mem_adr_q    <= '0;
            mem_wdata_q  <= '0;
            mem_w_q      <= 1'b0;
            mem_r_q      <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            mem_adr_q    <= mem_adr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_w_q      <= mem_w_d;
            mem_r_q      <= mem_r_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for round-robin and fixed-priority arbiter instances
module tb_dmem_arbiter;
    localparam logic [63:0] WDATA = 64'h0000ABCDEFFEDCBA;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   total = 0;
    logic [63:0] mem_a [0:127];
    logic [63:0] mem_b [0:127];

    dmem_arbiter_if a ();
    dmem_arbiter_if b ();

    dmem_arbiter #(.FIXED_PRIO(1'b0)) dut_rr (.clk(clk), .reset(reset), .bus_io(a.slave));
    dmem_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (.clk(clk), .reset(reset), .bus_io(b.slave));

    assign b.req_valid  = a.req_valid;
    assign b.req_we     = a.req_we;
    assign b.req_adr0   = a.req_adr0;
    assign b.req_adr1   = a.req_adr1;
    assign b.req_wdata0 = a.req_wdata0;
    assign b.req_wdata1 = a.req_wdata1;

    always #5 clk = ~clk;

    // Synchronous-read DataMemory models, one per arbiter instance
    always @(posedge clk) begin
        if (a.mem_w) mem_a[a.mem_adr[9:3]] <= a.mem_wdata;
        if (a.mem_r) a.mem_rdata <= mem_a[a.mem_adr[9:3]];
        if (b.mem_w) mem_b[b.mem_adr[9:3]] <= b.mem_wdata;
        if (b.mem_r) b.mem_rdata <= mem_b[b.mem_adr[9:3]];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++; if (a.mem_w !== 1'b0 || a.mem_r !== 1'b0) $display("FAIL rst_strobes: got w=%0b r=%0b want 0 0", a.mem_w, a.mem_r); else passed++;
        total++; if (a.rsp_valid !== 2'b00 || a.rsp_err !== 1'b0) $display("FAIL rst_rsp: got v=%b e=%0b want 00 0", a.rsp_valid, a.rsp_err); else passed++;
        total++; if (a.busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", a.busy); else passed++;
        total++; if (a.mem_adr !== 64'd0 || a.rsp_rdata !== 64'd0) $display("FAIL rst_data: got adr=%h rdata=%h want 0 0", a.mem_adr, a.rsp_rdata); else passed++;
        a.req_valid = 2'b01; a.req_we = 2'b00; a.req_adr0 = 64'd0;
        #1;
        total++; if (a.req_ready !== 2'b01) $display("FAIL rst_ready0: got %b want 01", a.req_ready); else passed++;
        a.req_valid = 2'b00;
        #1;
        total++; if (a.req_ready !== 2'b00) $display("FAIL withdraw_ready: got %b want 00", a.req_ready); else passed++;
    endtask

    task automatic test_write;
        a.req_valid = 2'b01; a.req_we = 2'b01; a.req_adr0 = 64'h50; a.req_wdata0 = WDATA;
        #1;
        total++; if (a.req_ready !== 2'b01) $display("FAIL wr_ready: got %b want 01", a.req_ready); else passed++;
        tick();
        a.req_valid = 2'b00;
        total++; if (a.mem_w !== 1'b1 || a.mem_r !== 1'b0) $display("FAIL wr_strobe: got w=%0b r=%0b want 1 0", a.mem_w, a.mem_r); else passed++;
        total++; if (a.mem_adr !== 64'h50 || a.mem_wdata !== WDATA) $display("FAIL wr_bus: got adr=%h wd=%h want 50 %h", a.mem_adr, a.mem_wdata, WDATA); else passed++;
        total++; if (a.busy !== 1'b1 || a.rsp_valid !== 2'b00) $display("FAIL wr_issue: got busy=%0b v=%b want 1 00", a.busy, a.rsp_valid); else passed++;
        tick();
        total++; if (a.mem_w !== 1'b0) $display("FAIL wr_pulse_len: got %0b want 0", a.mem_w); else passed++;
        total++; if (a.rsp_valid !== 2'b01 || a.rsp_err !== 1'b0) $display("FAIL wr_rsp: got v=%b e=%0b want 01 0", a.rsp_valid, a.rsp_err); else passed++;
        total++; if (a.req_ready !== 2'b00) $display("FAIL wr_no_accept_in_resp: got %b want 00", a.req_ready); else passed++;
        tick();
        total++; if (a.rsp_valid !== 2'b00 || a.busy !== 1'b0) $display("FAIL wr_idle: got v=%b busy=%0b want 00 0", a.rsp_valid, a.busy); else passed++;
        total++; if (a.mem_adr !== 64'h50) $display("FAIL wr_adr_hold: got %h want 50", a.mem_adr); else passed++;
        total++; if (mem_a[10] !== WDATA) $display("FAIL wr_mem: got %h want %h", mem_a[10], WDATA); else passed++;
    endtask

    task automatic test_read;
        a.req_valid = 2'b10; a.req_we = 2'b00; a.req_adr1 = 64'h50;
        #1;
        total++; if (a.req_ready !== 2'b10) $display("FAIL rd_ready: got %b want 10", a.req_ready); else passed++;
        tick();
        a.req_valid = 2'b00;
        total++; if (a.mem_r !== 1'b1 || a.mem_w !== 1'b0) $display("FAIL rd_strobe: got r=%0b w=%0b want 1 0", a.mem_r, a.mem_w); else passed++;
        tick();
        total++; if (a.mem_r !== 1'b0 || a.rsp_valid !== 2'b00) $display("FAIL rd_wait: got r=%0b v=%b want 0 00", a.mem_r, a.rsp_valid); else passed++;
        tick();
        total++; if (a.rsp_valid !== 2'b10 || a.rsp_err !== 1'b0) $display("FAIL rd_rsp: got v=%b e=%0b want 10 0", a.rsp_valid, a.rsp_err); else passed++;
        total++; if (a.rsp_rdata !== WDATA) $display("FAIL rd_data: got %h want %h", a.rsp_rdata, WDATA); else passed++;
        tick();
        total++; if (a.rsp_valid !== 2'b00 || a.rsp_rdata !== WDATA) $display("FAIL rd_hold: got v=%b d=%h want 00 %h", a.rsp_valid, a.rsp_rdata, WDATA); else passed++;
    endtask

    task automatic test_misaligned;
        a.req_valid = 2'b10; a.req_we = 2'b10; a.req_adr1 = 64'h13; a.req_wdata1 = 64'hDEAD;
        #1;
        total++; if (a.req_ready !== 2'b10) $display("FAIL mis_ready: got %b want 10", a.req_ready); else passed++;
        tick();
        a.req_valid = 2'b00;
        total++; if (a.rsp_valid !== 2'b10 || a.rsp_err !== 1'b1) $display("FAIL mis_rsp: got v=%b e=%0b want 10 1", a.rsp_valid, a.rsp_err); else passed++;
        total++; if (a.mem_w !== 1'b0 || a.mem_adr !== 64'h50) $display("FAIL mis_no_strobe: got w=%0b adr=%h want 0 50", a.mem_w, a.mem_adr); else passed++;
        tick();
        total++; if (a.rsp_valid !== 2'b00 || a.rsp_err !== 1'b0 || a.busy !== 1'b0) $display("FAIL mis_idle: got v=%b e=%0b busy=%0b want 00 0 0", a.rsp_valid, a.rsp_err, a.busy); else passed++;
        a.req_valid = 2'b01; a.req_we = 2'b00; a.req_adr0 = 64'h10;
        tick();
        a.req_valid = 2'b00;
        tick();
        tick();
        total++; if (a.rsp_valid !== 2'b01 || a.rsp_rdata !== 64'h1002) $display("FAIL mis_readback: got v=%b d=%h want 01 1002", a.rsp_valid, a.rsp_rdata); else passed++;
        tick();
    endtask

    task automatic test_arbitration;
        logic [1:0]  ea;
        logic [63:0] ed;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        a.req_valid = 2'b11; a.req_we = 2'b00; a.req_adr0 = 64'h08; a.req_adr1 = 64'h18;
        for (int i = 0; i < 4; i++) begin
            ea = (i % 2 == 1) ? 2'b10 : 2'b01;
            ed = (i % 2 == 1) ? 64'h1003 : 64'h1001;
            #1;
            total++; if (a.req_ready !== ea) $display("FAIL rr_grant%0d: got %b want %b", i, a.req_ready, ea); else passed++;
            total++; if (b.req_ready !== 2'b01) $display("FAIL fp_grant%0d: got %b want 01", i, b.req_ready); else passed++;
            tick();
            tick();
            tick();
            total++; if (a.rsp_valid !== ea || a.rsp_rdata !== ed) $display("FAIL rr_rsp%0d: got v=%b d=%h want %b %h", i, a.rsp_valid, a.rsp_rdata, ea, ed); else passed++;
            total++; if (b.rsp_valid !== 2'b01 || b.rsp_rdata !== 64'h1001) $display("FAIL fp_rsp%0d: got v=%b d=%h want 01 1001", i, b.rsp_valid, b.rsp_rdata); else passed++;
            tick();
        end
        a.req_valid = 2'b00;
    endtask

    task automatic test_reset_mid;
        a.req_valid = 2'b01; a.req_we = 2'b00; a.req_adr0 = 64'h50;
        tick();
        a.req_valid = 2'b00;
        tick();
        total++; if (a.busy !== 1'b1 || a.mem_r !== 1'b0) $display("FAIL mid_wait: got busy=%0b r=%0b want 1 0", a.busy, a.mem_r); else passed++;
        reset = 1'b1;
        tick();
        total++; if (a.rsp_valid !== 2'b00 || a.busy !== 1'b0 || a.mem_r !== 1'b0) $display("FAIL mid_reset: got v=%b busy=%0b r=%0b want 00 0 0", a.rsp_valid, a.busy, a.mem_r); else passed++;
        reset = 1'b0;
        tick();
        total++; if (a.rsp_valid !== 2'b00) $display("FAIL mid_dropped: got %b want 00", a.rsp_valid); else passed++;
        a.req_valid = 2'b01;
        #1;
        total++; if (a.req_ready !== 2'b01) $display("FAIL mid_reissue_ready: got %b want 01", a.req_ready); else passed++;
        tick();
        a.req_valid = 2'b00;
        tick();
        tick();
        total++; if (a.rsp_valid !== 2'b01 || a.rsp_rdata !== WDATA) $display("FAIL mid_reissue_rsp: got v=%b d=%h want 01 %h", a.rsp_valid, a.rsp_rdata, WDATA); else passed++;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem_a[i] = 64'h1000 + 64'(i);
            mem_b[i] = 64'h1000 + 64'(i);
        end
        a.req_valid = 2'b00; a.req_we = 2'b00;
        a.req_adr0 = '0; a.req_adr1 = '0; a.req_wdata0 = '0; a.req_wdata1 = '0;
        a.mem_rdata = '0; b.mem_rdata = '0;
        test_reset();
        test_write();
        test_read();
        test_misaligned();
        test_arbitration();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-ported DataMemory (64-bit address and data, `w`/`r` strobes, synchronous read).
- Port 0 is the CPU load/store path; port 1 is an auxiliary master (loader/debug).
- Accepts one request at a time through a valid/ready handshake and drives the memory strobes for exactly one cycle.
- Returns the write-ack or read-data response on a one-cycle `rsp_valid` pulse to the requester that issued it.

Parameters:
- ADDR_W, 64, address width of requests and of `mem_adr`.
- DATA_W, 64, data width of write and read data.
- FIXED_PRIO, 0: 0 = round-robin between ports; 1 = port 0 always wins.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  per-port request valid (bit i = port i).
- req_we  in  2  per-port 1=write, 0=read.
- req_adr0, req_adr1  in  ADDR_W  per-port byte address.
- req_wdata0, req_wdata1  in  DATA_W  per-port write data.
- req_ready  out  2  per-port accept; transfer when valid&ready at rising edge.
- rsp_valid  out  2  per-port one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; meaningful only when any `rsp_valid` bit is set and the request was a read.
- rsp_err  out  1  misaligned-address error, qualified by `rsp_valid`.
- mem_adr  out  ADDR_W  to DataMemory `adr`.
- mem_wdata  out  DATA_W  to DataMemory `datain`.
- mem_w  out  1  to DataMemory `w`.
- mem_r  out  1  to DataMemory `r`.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values, registered outputs:
  - `mem_w`, `mem_r`, `rsp_valid`, `rsp_err` = 0.
  - `mem_adr`, `mem_wdata`, `rsp_rdata` = 0.
  - state = IDLE; `last_grant` = 1, so port 0 is favoured first.
- Reset mid-operation: any in-flight request is dropped without a response; strobes are 0 from the cycle after the reset edge.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `grant` is combinational. If exactly one `req_valid` bit is set, that port wins.
  - If both are set: with FIXED_PRIO=1, port 0 wins; with FIXED_PRIO=0, the port != `last_grant` wins.
  - `req_ready[grant]` = 1 only in IDLE with its valid set. The two `req_ready` bits are never high together.
  - On accept: latch port id, `we`, `adr`, `wdata`; update `last_grant`; go to ISSUE.
- Misaligned request (`adr[2:0] != 0`): go directly to RESP with `rsp_err` = 1. No memory strobe is issued.
- ISSUE (one cycle):
  - `mem_adr`/`mem_wdata` hold the latched values.
  - `mem_w` = `we`, `mem_r` = !`we`; exactly one strobe is high.
  - Next state: WAIT if read, RESP if write.
- WAIT (one cycle): strobes are 0; DataMemory `dataout` is valid and is registered into `rsp_rdata`; go to RESP.
- RESP (one cycle):
  - `rsp_valid[id]` = 1, `rsp_err` as latched, `rsp_rdata` held.
  - Return to IDLE; a new accept is possible in the same cycle `rsp_valid` is high? No: accept is possible on the next cycle only.
- Latency from accept edge:
  - Write: `mem_w` high 1 cycle later, `rsp_valid` 2 cycles later.
  - Read: `mem_r` 1 cycle later, `rsp_valid` 3 cycles later.
  - Misaligned: `rsp_valid` 1 cycle later.
- Responses have no backpressure; the requester must take the pulse.
- Requesters hold `valid` and payload stable until `ready`. Dropping `valid` before `ready` withdraws the request.
- `mem_adr`/`mem_wdata` keep their last values outside ISSUE; only the strobes return to 0.
- `rsp_rdata` holds until the next read response.
- Simultaneous `req_valid` change and grant: arbitration samples the current-cycle values only.

Test Plan:
- Reset → all strobes and `rsp_valid` are 0 and `busy` = 0. Port 0 read at adr 0 → `req_ready[0]` = 1 on the first cycle.
- Port 0 write adr 0x50, wdata 64'h0000ABCDEFFEDCBA → `mem_w` = 1 for exactly 1 cycle, `mem_adr` = 0x50; `rsp_valid[0]` 2 cycles after accept with `rsp_err` = 0.
- Port 1 read adr 0x50 after that write → `mem_r` pulse of 1 cycle; `rsp_valid[1]` 3 cycles after accept with `rsp_rdata` = 64'h0000ABCDEFFEDCBA.
- Both ports hold valid for 4 back-to-back reads, FIXED_PRIO=0 → grant order 0,1,0,1. With FIXED_PRIO=1 → 0,0,0,0 while port 0 stays valid.
- Port 1 write to adr 0x13 → no `mem_w` pulse; `rsp_valid[1]` + `rsp_err` = 1 one cycle after accept; memory at 0x10 unchanged on readback.
- Reset asserted during WAIT of a read → no `rsp_valid`, state IDLE, `mem_r` = 0. Reissued request completes normally.
